metropolis_pipe: RTL and testbench
==================================

Name: metropolis_pipe

Overview:
- Synthesizable, pipelined successor to the per-replica Metropolis acceptance unit.
- Replaces the real-valued exp() test with a fixed-point base-2 exp (LUT plus shift), so the design can be built.
- Parametrised in widths, fraction bits, LUT depth and replica index; accepts one candidate move per cycle at a fixed latency.
- Owns the replica's total-distance register and the replica-exchange data path. One instance per replica sits between the delta-distance calculator and the exchange chain.

Parameters:
- ID, 0, replica index; beta_q = (ID+1)*DBETA.
- DBETA, replica_pkg::dbeta, integer beta step.
- DW, 24, signed delta_distance width.
- TW, $bits(total_data_t), total-distance width.
- FRAC, 17, fraction bits of delta_distance.
- LUT_AW, 8, index bits of the 2^-f table.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-low reset
- distance_shift  in  1  load prev_data into out_data (init/shift chain)
- in_valid  in  1  candidate move present
- in_opt  in  opt_t  move descriptor {K,L,command}
- delta_distance  in  DW  signed distance change, Q(DW-FRAC).FRAC
- r_metropolis  in  32  uniform random, Q0.32
- command  in  exchange_command_t  NOP/PREV/FOLW exchange
- prev_data  in  total_data_t  neighbour (previous) total
- folw_data  in  total_data_t  neighbour (following) total
- out_valid  out  1  result valid
- out_accept  out  1  Metropolis test passed
- out_opt  out  opt_t  resolved move command
- out_data  out  total_data_t  replica total distance
- busy  out  1  any pipeline stage valid

Behaviour:
- Reset (reset==0 at clk edge):
  - all stage valids = 0, out_valid = 0, out_accept = 0;
  - out_opt = {K:0, L:0, command:THR}, out_data = 0, busy = 0.
- Pipeline: 4 stages, fully pipelined. in_valid at edge n gives out_valid high after edge n+4. No back-pressure.
- S1 (register the input):
  - neg = (delta_distance <= 0);
  - p1 = unsigned(delta) * beta_q, width DW+16, computed only when !neg, else forced to 0.
- S2:
  - y = (p1 * LOG2E_Q) >> 16, where LOG2E_Q = 94548 (log2 e in Q1.16);
  - i = y >> FRAC, saturated to 6 bits;
  - f = y[FRAC-1 -: LUT_AW].
- S3:
  - m = LUT[f], with LUT[k] = round(2^32 * 2^(-k/2^LUT_AW)); LUT[0] saturates to 0xFFFFFFFF;
  - e = (i >= 32) ? 0 : m >> i.
- S4: test = neg || (e > r_metropolis), where r is the value carried down the pipeline.
  - out_accept = test & valid.
  - out_opt.K/L pass through.
  - out_opt.command:
    - THR if in command == THR;
    - otherwise, if test: TWO if command == TWO, else OR0 if K < L, else OR1;
    - otherwise THR.
- out_data write priority (evaluated every edge):
  1. distance_shift -> prev_data;
  2. command == PREV -> prev_data;
  3. command == FOLW -> folw_data;
  4. S4 valid & test -> out_data + sign-extended delta (wraps modulo 2^TW);
  5. hold.
- Exchange coincident with an accept: the exchange wins, and the accept's delta is dropped.
- PREV/FOLW/distance_shift also clear the valids of all stages (flush). out_valid for flushed moves never asserts; the upstream block re-issues them.
- Reset mid-operation: in-flight moves are discarded and nothing reaches the outputs.
- busy = OR of stage valids; upstream uses it to gate exchange until the pipe drains.
- Invalid cycles carry bubbles. out_opt and out_accept are don't-care when out_valid == 0 (hold last value).

Decomposition:
- replica_pkg: opt_t, exchange_command_t, total_data_t, dbeta, LOG2E_Q, and function exp2_lut(k, LUT_AW) that generates the table at elaboration.
- One sub-module, exp2_neg_fx: S2–S3 (y to e, 2-stage). Isolated so it can be unit-tested and later shared.

Test Plan:
- Zero move: ID=0, DBETA=1, delta=0, r=0xFFFFFFFF, opt {3,7,OR0} -> out_valid at +4, accept=1, command=OR0, out_data unchanged.
- Downhill move: delta=-1000, out_data=50000, opt {9,2,OR0} -> accept=1, command=OR1, out_data=49000 at +4.
- exp(-1) threshold: delta=1<<17 (x=1.0, e≈0x5E2D58D8, ±1%):
  - r=0x5C000000 -> accept, out_data += 131072;
  - r=0x60000000 -> reject, command=THR, out_data held.
- Large uphill move: delta=0x7FFFFF, r=0 -> e=0, reject, THR.
- Back-to-back moves: 8 consecutive valid moves with mixed delta -> 8 consecutive out_valids in order; final out_data equals the sum of accepted deltas.
- Flush, then reset:
  - Flush: command=FOLW at the cycle an accepted move is in S4 -> out_data=folw_data, move dropped, busy=0 next cycle.
  - Reset: reset=0 mid-stream -> all outputs at reset values next edge.

Source files
------------

// File: rtl/replica_pkg.sv
// -----------------------------------------------------------------------------
// replica_pkg
// Shared types and constants for the per-replica Metropolis acceptance pipe.
//   opt_t              : move descriptor {K, L, command}
//   move_cmd_t         : resolved move command (THR/TWO/OR0/OR1)
//   exchange_command_t : replica-exchange request (NOP/PREV/FOLW)
//   total_data_t       : replica total-distance word
//   dbeta, LOG2E_Q     : integer beta step and log2(e) in Q1.16
//   exp2_lut()         : elaboration-time generator for the 2^-f table
// -----------------------------------------------------------------------------
package replica_pkg;

   localparam int dbeta   = 1;
   localparam int LOG2E_Q = 94548;   // round(log2(e) * 2^16)
   localparam int IDX_W   = 8;       // width of the K/L move indices

   typedef logic [31:0] total_data_t;

   typedef enum logic [1:0] {
      NOP  = 2'd0,
      PREV = 2'd1,
      FOLW = 2'd2
   } exchange_command_t;

   typedef enum logic [1:0] {
      THR = 2'd0,
      TWO = 2'd1,
      OR0 = 2'd2,
      OR1 = 2'd3
   } move_cmd_t;

   typedef struct packed {
      logic [IDX_W-1:0] K;
      logic [IDX_W-1:0] L;
      move_cmd_t        command;
   } opt_t;

   // Entry k of the table holds round(2^32 * 2^(-k / 2^aw)). Entry 0 would be
   // exactly 2^32, which does not fit, so it saturates to all ones.
   function automatic logic [31:0] exp2_lut(input int k, input int aw);
      real v;
      v = 4294967296.0 * (2.0 ** (-(real'(k)) / real'(1 << aw)));
      if (v >= 4294967295.0) return 32'hFFFF_FFFF;
      return 32'(longint'(v));   // real-to-integer cast rounds to nearest
   endfunction

endpackage

// File: rtl/exp2_neg_fx.sv
// -----------------------------------------------------------------------------
// exp2_neg_fx
// Two-stage fixed-point evaluation of e = 2^32 * 2^(-y).
//   Stage A: split y into integer part i (saturated to 6 bits) and the top
//            LUT_AW fraction bits f.
//   Stage B: e = LUT[f] >> i, forced to 0 once i >= 32.
// Ports:
//   clk, reset : clock, synchronous active-low reset
//   yt         : y pre-shifted right by (FRAC - LUT_AW); the low fraction bits
//                below the table resolution are never needed here
//   e          : result, Q0.32, valid two cycles after yt
// -----------------------------------------------------------------------------
module exp2_neg_fx
   import replica_pkg::*;
#(
   parameter int YTW    = 33,
   parameter int LUT_AW = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [YTW-1:0]  yt,
   output logic [31:0]     e
);

   localparam int LUT_N = 1 << LUT_AW;

   logic [31:0] lut [LUT_N];

   for (genvar k = 0; k < LUT_N; k++) begin : g_lut
      localparam logic [31:0] VAL = exp2_lut(k, LUT_AW);
      assign lut[k] = VAL;
   end

   logic [YTW-1:0]    ipart;
   logic [5:0]        i_d, i_q;
   logic [LUT_AW-1:0] f_d, f_q;
   logic [31:0]       e_d, e_q;

   always_comb begin
      ipart = yt >> LUT_AW;
      i_d   = (ipart > YTW'(63)) ? 6'd63 : ipart[5:0];
      f_d   = yt[LUT_AW-1:0];
      // Any shift of 32 or more empties a 32-bit word.
      e_d   = (i_q >= 6'd32) ? 32'd0 : (lut[f_q] >> i_q);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         i_q <= '0;
         f_q <= '0;
         e_q <= '0;
      end else begin
         i_q <= i_d;
         f_q <= f_d;
         e_q <= e_d;
      end
   end

   assign e = e_q;

endmodule

// File: rtl/metropolis_pipe.sv
// -----------------------------------------------------------------------------
// metropolis_pipe
// Per-replica Metropolis acceptance unit, 4 pipeline stages plus output
// register, one candidate per cycle, no back-pressure. Also owns the replica
// total-distance register and the replica-exchange load path.
// Ports:
//   clk, reset      : clock, synchronous active-low reset
//   distance_shift  : load prev_data into out_data (init / shift chain)
//   in_valid        : candidate move present this cycle
//   in_opt          : move descriptor {K, L, command}
//   delta_distance  : signed distance change, FRAC fraction bits
//   r_metropolis    : uniform random threshold, Q0.32
//   command         : exchange request NOP / PREV / FOLW
//   prev_data       : previous neighbour's total
//   folw_data       : following neighbour's total
//   out_valid       : result valid
//   out_accept      : Metropolis test passed
//   out_opt         : resolved move command
//   out_data        : replica total distance
//   busy            : any pipeline stage holds a move
// Valid semantics: a move is accepted whenever in_valid is high at a clock
// edge; out_valid pulses for exactly one cycle four edges later unless an
// exchange or distance_shift flushes the pipe in between. There is no ready.
// -----------------------------------------------------------------------------
module metropolis_pipe
   import replica_pkg::*;
#(
   parameter int ID     = 0,
   parameter int DBETA  = dbeta,
   parameter int DW     = 24,
   parameter int TW     = $bits(total_data_t),
   parameter int FRAC   = 17,
   parameter int LUT_AW = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              distance_shift,
   input  logic              in_valid,
   input  opt_t              in_opt,
   input  logic [DW-1:0]     delta_distance,
   input  logic [31:0]       r_metropolis,
   input  exchange_command_t command,
   input  total_data_t       prev_data,
   input  total_data_t       folw_data,
   output logic              out_valid,
   output logic              out_accept,
   output opt_t              out_opt,
   output total_data_t       out_data,
   output logic              busy
);

   localparam int BETA_Q = (ID + 1) * DBETA;
   localparam int PW     = DW + 16;                  // p1 width
   localparam int MW     = PW + 17;                  // p1 * LOG2E_Q width
   localparam int YTW    = DW + 17 - (FRAC - LUT_AW);

   logic flush;

   // S1: registered input plus beta-scaled magnitude
   logic          s1_valid_d, s1_valid_q;
   logic          s1_neg_d,   s1_neg_q;
   logic [PW-1:0] s1_p1_d,    s1_p1_q;
   logic [31:0]   s1_r_d,     s1_r_q;
   logic [DW-1:0] s1_delta_d, s1_delta_q;
   opt_t          s1_opt_d,   s1_opt_q;

   // S2/S3: side-band riding alongside exp2_neg_fx
   logic          s2_valid_d, s2_valid_q, s3_valid_d, s3_valid_q;
   logic          s2_neg_d,   s2_neg_q,   s3_neg_d,   s3_neg_q;
   logic [31:0]   s2_r_d,     s2_r_q,     s3_r_d,     s3_r_q;
   logic [DW-1:0] s2_delta_d, s2_delta_q, s3_delta_d, s3_delta_q;
   opt_t          s2_opt_d,   s2_opt_q,   s3_opt_d,   s3_opt_q;

   // S4: registered test result
   logic          s4_valid_d, s4_valid_q;
   logic          s4_test_d,  s4_test_q;
   logic [DW-1:0] s4_delta_d, s4_delta_q;
   opt_t          s4_opt_d,   s4_opt_q;

   // Output registers
   logic          out_valid_d,  out_valid_q;
   logic          out_accept_d, out_accept_q;
   opt_t          out_opt_d,    out_opt_q;
   total_data_t   out_data_d,   out_data_q;

   logic [YTW-1:0] yt;
   logic [31:0]    e;

   exp2_neg_fx #(
      .YTW    (YTW),
      .LUT_AW (LUT_AW)
   ) u_exp2 (
      .clk   (clk),
      .reset (reset),
      .yt    (yt),
      .e     (e)
   );

   always_comb begin
      // Exchange and chain loads replace the total the in-flight moves were
      // computed against, so every stage is dropped and upstream re-issues.
      flush = distance_shift || (command == PREV) || (command == FOLW);

      // S1
      s1_valid_d = in_valid && !flush;
      s1_neg_d   = ($signed(delta_distance) <= 0);
      s1_p1_d    = s1_neg_d ? '0 : (PW'(delta_distance) * PW'(BETA_Q));
      s1_r_d     = r_metropolis;
      s1_delta_d = delta_distance;
      s1_opt_d   = in_opt;

      // y = p1 * log2(e), keeping only the bits the table lookup consumes.
      yt = YTW'((MW'(s1_p1_q) * MW'(LOG2E_Q)) >> (16 + FRAC - LUT_AW));

      // S2
      s2_valid_d = s1_valid_q && !flush;
      s2_neg_d   = s1_neg_q;
      s2_r_d     = s1_r_q;
      s2_delta_d = s1_delta_q;
      s2_opt_d   = s1_opt_q;

      // S3
      s3_valid_d = s2_valid_q && !flush;
      s3_neg_d   = s2_neg_q;
      s3_r_d     = s2_r_q;
      s3_delta_d = s2_delta_q;
      s3_opt_d   = s2_opt_q;

      // S4: e is aligned with the S3 side-band here.
      s4_valid_d = s3_valid_q && !flush;
      s4_test_d  = s3_neg_q || (e > s3_r_q);
      s4_delta_d = s3_delta_q;
      s4_opt_d   = s3_opt_q;

      // Output stage; opt/accept hold their last value on bubbles.
      out_valid_d  = s4_valid_q && !flush;
      out_accept_d = out_accept_q;
      out_opt_d    = out_opt_q;
      if (out_valid_d) begin
         out_accept_d  = s4_test_q;
         out_opt_d.K   = s4_opt_q.K;
         out_opt_d.L   = s4_opt_q.L;
         if (s4_opt_q.command == THR || !s4_test_q) begin
            out_opt_d.command = THR;
         end else if (s4_opt_q.command == TWO) begin
            out_opt_d.command = TWO;
         end else begin
            out_opt_d.command = (s4_opt_q.K < s4_opt_q.L) ? OR0 : OR1;
         end
      end

      // Total-distance register: loads beat a coincident accept.
      if (distance_shift) begin
         out_data_d = prev_data;
      end else if (command == PREV) begin
         out_data_d = prev_data;
      end else if (command == FOLW) begin
         out_data_d = folw_data;
      end else if (s4_valid_q && s4_test_q) begin
         out_data_d = out_data_q + {{(TW-DW){s4_delta_q[DW-1]}}, s4_delta_q};
      end else begin
         out_data_d = out_data_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         s1_valid_q   <= 1'b0;
         s1_neg_q     <= 1'b0;
         s1_p1_q      <= '0;
         s1_r_q       <= '0;
         s1_delta_q   <= '0;
         s1_opt_q     <= '0;
         s2_valid_q   <= 1'b0;
         s2_neg_q     <= 1'b0;
         s2_r_q       <= '0;
         s2_delta_q   <= '0;
         s2_opt_q     <= '0;
         s3_valid_q   <= 1'b0;
         s3_neg_q     <= 1'b0;
         s3_r_q       <= '0;
         s3_delta_q   <= '0;
         s3_opt_q     <= '0;
         s4_valid_q   <= 1'b0;
         s4_test_q    <= 1'b0;
         s4_delta_q   <= '0;
         s4_opt_q     <= '0;
         out_valid_q  <= 1'b0;
         out_accept_q <= 1'b0;
         out_opt_q    <= '{K: '0, L: '0, command: THR};
         out_data_q   <= '0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_neg_q     <= s1_neg_d;
         s1_p1_q      <= s1_p1_d;
         s1_r_q       <= s1_r_d;
         s1_delta_q   <= s1_delta_d;
         s1_opt_q     <= s1_opt_d;
         s2_valid_q   <= s2_valid_d;
         s2_neg_q     <= s2_neg_d;
         s2_r_q       <= s2_r_d;
         s2_delta_q   <= s2_delta_d;
         s2_opt_q     <= s2_opt_d;
         s3_valid_q   <= s3_valid_d;
         s3_neg_q     <= s3_neg_d;
         s3_r_q       <= s3_r_d;
         s3_delta_q   <= s3_delta_d;
         s3_opt_q     <= s3_opt_d;
         s4_valid_q   <= s4_valid_d;
         s4_test_q    <= s4_test_d;
         s4_delta_q   <= s4_delta_d;
         s4_opt_q     <= s4_opt_d;
         out_valid_q  <= out_valid_d;
         out_accept_q <= out_accept_d;
         out_opt_q    <= out_opt_d;
         out_data_q   <= out_data_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_accept = out_accept_q;
   assign out_opt    = out_opt_q;
   assign out_data   = out_data_q;
   assign busy       = s1_valid_q | s2_valid_q | s3_valid_q | s4_valid_q;

endmodule

// File: tb/tb_metropolis_pipe.sv
// -----------------------------------------------------------------------------
// tb_metropolis_pipe
// Self-checking bench for metropolis_pipe (ID=0, DBETA=1). Expected results
// are pushed when a move is driven and popped when out_valid is seen.
// -----------------------------------------------------------------------------
module tb_metropolis_pipe;
   import replica_pkg::*;

   localparam int EW   = 1 + 2 + 8 + 8 + 24;   // {accept, cmd, K, L, delta}
   localparam int BETA = 1;

   logic              clk;
   logic              reset;
   logic              distance_shift;
   logic              in_valid;
   opt_t              in_opt;
   logic [23:0]       delta_distance;
   logic [31:0]       r_metropolis;
   exchange_command_t command;
   total_data_t       prev_data;
   total_data_t       folw_data;
   logic              out_valid;
   logic              out_accept;
   opt_t              out_opt;
   total_data_t       out_data;
   logic              busy;

   logic [EW-1:0] exp_q[$];
   total_data_t   model_total;
   int            n_checks;
   int            n_fail;
   int            n_out;

   metropolis_pipe dut (
      .clk            (clk),
      .reset          (reset),
      .distance_shift (distance_shift),
      .in_valid       (in_valid),
      .in_opt         (in_opt),
      .delta_distance (delta_distance),
      .r_metropolis   (r_metropolis),
      .command        (command),
      .prev_data      (prev_data),
      .folw_data      (folw_data),
      .out_valid      (out_valid),
      .out_accept     (out_accept),
      .out_opt        (out_opt),
      .out_data       (out_data),
      .busy           (busy)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   // ---------------- reference model ----------------
   // e = 2^32 * exp(-x), x = delta * beta / 2^17; zero once x*log2(e) >= 32.
   function automatic real e_model(input int d);
      real x;
      x = real'(d) * real'(BETA) / 131072.0;
      if (x * 1.4426950409 >= 32.0) return 0.0;
      return 4294967296.0 * $exp(-x);
   endfunction

   function automatic move_cmd_t exp_cmd(input logic acc, input move_cmd_t c,
                                         input logic [7:0] k, input logic [7:0] l);
      if (c == THR || !acc) return THR;
      if (c == TWO) return TWO;
      return (k < l) ? OR0 : OR1;
   endfunction

   // ---------------- drivers ----------------
   task automatic drive_move(input int d, input logic [31:0] r, input int k,
                             input int l, input move_cmd_t c);
      logic      acc;
      move_cmd_t ec;
      acc = (d <= 0) || (e_model(d) > real'(r));
      ec  = exp_cmd(acc, c, k[7:0], l[7:0]);
      in_valid       = 1'b1;
      delta_distance = 24'(d);
      r_metropolis   = r;
      in_opt.K       = k[7:0];
      in_opt.L       = l[7:0];
      in_opt.command = c;
      exp_q.push_back({acc, ec, k[7:0], l[7:0], 24'(d)});
      @(negedge clk);
   endtask

   task automatic load_total(input total_data_t v);
      distance_shift = 1'b1;
      prev_data      = v;
      @(negedge clk);
      distance_shift = 1'b0;
      model_total    = v;
      chk("load_total", out_data, v);
   endtask

   task automatic wait_drain();
      for (int c = 0; c < 40; c++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      chk("drain_left", exp_q.size(), 0);
      @(negedge clk);
   endtask

   task automatic check_reset_state();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_accept", out_accept, 0);
      chk("rst_out_opt", out_opt, 18'd0);   // {K:0, L:0, THR}
      chk("rst_out_data", out_data, 0);
      chk("rst_busy", busy, 0);
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin : monitor
      logic [EW-1:0] ex;
      if (reset && out_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_out_valid", 1, 0);
         end else begin
            ex = exp_q.pop_front();
            n_out++;
            chk("accept", out_accept, ex[42]);
            chk("cmd", out_opt.command, ex[41:40]);
            chk("k", out_opt.K, ex[39:32]);
            chk("l", out_opt.L, ex[31:24]);
            if (ex[42]) model_total = model_total + {{8{ex[23]}}, ex[23:0]};
            chk("out_data", out_data, model_total);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int  out_before;
      int  d;
      real ev;
      real rr;
      logic [31:0] r;

      n_checks = 0; n_fail = 0; n_out = 0; model_total = '0;
      reset = 1'b0; distance_shift = 1'b0; in_valid = 1'b0; in_opt = '0;
      delta_distance = '0; r_metropolis = '0; command = NOP;
      prev_data = '0; folw_data = '0;
      repeat (3) @(negedge clk);
      check_reset_state();
      reset = 1'b1;
      @(negedge clk);

      // Zero move with latency check: out_valid exactly four edges later.
      drive_move(0, 32'hFFFF_FFFF, 3, 7, OR0);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("lat_early", out_valid, 0);
      chk("busy_inflight", busy, 1);
      @(negedge clk);
      chk("lat_hit", out_valid, 1);
      wait_drain();

      // Downhill move.
      load_total(50000);
      drive_move(-1000, 32'h1234_5678, 9, 2, OR0);
      in_valid = 1'b0;
      wait_drain();
      chk("downhill_total", out_data, 49000);

      // exp(-1) threshold on both sides, then a hopeless uphill move.
      drive_move(1 << 17, 32'h5C00_0000, 1, 2, OR0);
      drive_move(1 << 17, 32'h6000_0000, 4, 5, OR0);
      drive_move(24'h7F_FFFF, 32'h0, 6, 1, OR1);
      // Accepted moves with TWO and THR commands.
      drive_move(-3, 32'h0, 5, 9, TWO);
      drive_move(-4, 32'h0, 5, 9, THR);
      in_valid = 1'b0;
      wait_drain();
      chk("thresh_total", out_data, 49000 + 131072 - 7);

      // Eight back-to-back moves with mixed deltas.
      out_before = n_out;
      for (int n = 0; n < 8; n++) begin
         case ($urandom_range(0, 3))
            0: begin d = -int'($urandom_range(1, 500000)); r = $urandom(); end
            1: begin d = 0; r = $urandom(); end
            2: begin d = 24'h40_0000 + int'($urandom_range(0, 1000)); r = $urandom_range(0, 1000); end
            default: begin
               d  = int'($urandom_range(1, 3 << 17));
               ev = e_model(d);
               rr = ($urandom_range(0, 1) == 1) ? ev * 0.9 : ev * 1.1;
               if (rr > 4294967295.0) rr = 4294967295.0;
               r  = 32'(longint'(rr));
            end
         endcase
         drive_move(d, r, n, int'($urandom_range(0, 15)), OR0);
      end
      in_valid = 1'b0;
      wait_drain();
      chk("b2b_count", n_out - out_before, 8);

      // Flush: FOLW lands while an accepted move sits in S4.
      drive_move(-5, 32'h0, 1, 2, OR0);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("busy_before_flush", busy, 1);
      command   = FOLW;
      folw_data = 32'd777777;
      exp_q.delete();
      @(negedge clk);
      command = NOP;
      model_total = 32'd777777;
      chk("flush_out_valid", out_valid, 0);
      chk("flush_out_data", out_data, 777777);
      chk("flush_busy", busy, 0);
      repeat (6) @(negedge clk);

      // Reset with moves in flight.
      drive_move(-11, 32'h0, 2, 3, OR0);
      drive_move(-12, 32'h0, 3, 4, OR0);
      drive_move(-13, 32'h0, 4, 5, OR0);
      reset    = 1'b0;
      in_valid = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check_reset_state();
      model_total = '0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (8) @(negedge clk);

      // Recovery after reset; negative delta wraps the unsigned total.
      drive_move(-7, 32'h0, 0, 1, OR0);
      in_valid = 1'b0;
      wait_drain();
      chk("wrap_total", out_data, 32'hFFFF_FFF9);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
